// File: rtl/cic_decim_comb.sv
// cic_decim_comb -- decimator and comb section of a CIC decimation filter.
//
// Takes the full-rate output of the CIC integrator chain. Keeps one sample
// in every DECIMATION samples and passes it through STAGES pipelined comb
// (differentiator) stages. The narrowed result is emitted with a one-cycle
// valid strobe at the decimated rate.
//
// Ports:
//   clk_in      clock, same domain as the integrator chain
//   rst         synchronous, active-high reset
//   din         signed integrator output, valid every clk_in cycle
//   dout        signed decimated output: top DOUT_WIDTH bits of the comb result
//   dout_valid  one-cycle strobe; dout is valid while it is high
//
// Optional build macro CIC_ROUND_EN: rounds half up before width reduction
// and saturates a positive overflow to +max. This adds one pipeline register.
// When DIN_WIDTH == DOUT_WIDTH the macro has no effect.

// One comb stage: y = x - x delayed by M decimated samples.
module cic_comb_stage #(
  parameter int W = 32,
  parameter int M = 1
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  logic [M-1:0][W-1:0] dl;

  // Modulo-2^W subtraction. Wrap-around is intentional: the integrators
  // overflow, and the combs must cancel that overflow exactly.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      y  <= '0;
      dl <= '0;
    end else if (en) begin
      y     <= x - dl[M-1];
      dl[0] <= x;
      for (int i = 1; i < M; i++) dl[i] <= dl[i-1];
    end
  end
endmodule

module cic_decim_comb #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int STAGES     = 3,
  parameter int DECIMATION = 8,
  parameter int DIFF_DELAY = 1
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  din,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_valid
);
  generate
    if (DOUT_WIDTH > DIN_WIDTH || DOUT_WIDTH < 1) begin : g_bad_width
      $error("cic_decim_comb: DOUT_WIDTH must be in 1..DIN_WIDTH");
    end
    if (DIFF_DELAY != 1 && DIFF_DELAY != 2) begin : g_bad_delay
      $error("cic_decim_comb: DIFF_DELAY must be 1 or 2");
    end
    if (DECIMATION < 1 || STAGES < 1) begin : g_bad_rate
      $error("cic_decim_comb: DECIMATION and STAGES must be >= 1");
    end
  endgenerate

  localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIMATION - 1);

  logic [CW-1:0]                   cnt;
  logic                            cap;
  logic [STAGES:0]                 vld_pipe;  // [0] = sample captured, [k] = comb k done
  logic [DIN_WIDTH-1:0]            sample;
  logic [STAGES:0][DIN_WIDTH-1:0]  comb_d;    // [0] = sample, [k] = comb k output

  assign cap = (cnt == CNT_LAST);

  // With DECIMATION == 1 the counter stays at 0 and every cycle is a capture.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt      <= '0;
      sample   <= '0;
      vld_pipe <= '0;
    end else begin
      cnt      <= cap ? '0 : cnt + CW'(1);
      vld_pipe <= {vld_pipe[STAGES-1:0], cap};
      if (cap) sample <= din;
    end
  end

  assign comb_d[0] = sample;

  generate
    for (genvar k = 1; k <= STAGES; k++) begin : g_comb
      cic_comb_stage #(.W(DIN_WIDTH), .M(DIFF_DELAY)) u_stage (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (vld_pipe[k-1]),
        .x      (comb_d[k-1]),
        .y      (comb_d[k])
      );
    end
  endgenerate

  logic [DIN_WIDTH-1:0] fin;
  logic                 fin_vld;

`ifdef CIC_ROUND_EN
  generate
    if (DIN_WIDTH > DOUT_WIDTH) begin : g_round
      localparam logic [DIN_WIDTH-1:0] HALF    = DIN_WIDTH'(1) << (DIN_WIDTH - DOUT_WIDTH - 1);
      localparam logic [DIN_WIDTH-1:0] POS_MAX = {1'b0, {(DIN_WIDTH-1){1'b1}}};
      logic [DIN_WIDTH-1:0] rsum, rnd_q;
      logic                 rnd_vld;

      assign rsum = comb_d[STAGES] + HALF;

      // Adding HALF can only overflow from positive to negative; clamp that
      // case to +max so truncation yields 0111...1.
      always_ff @(posedge clk_in) begin
        if (rst) begin
          rnd_q   <= '0;
          rnd_vld <= 1'b0;
        end else begin
          rnd_vld <= vld_pipe[STAGES];
          if (vld_pipe[STAGES])
            rnd_q <= (!comb_d[STAGES][DIN_WIDTH-1] && rsum[DIN_WIDTH-1]) ? POS_MAX : rsum;
        end
      end

      assign fin     = rnd_q;
      assign fin_vld = rnd_vld;
    end else begin : g_pass
      assign fin     = comb_d[STAGES];
      assign fin_vld = vld_pipe[STAGES];
    end
  endgenerate
`else
  assign fin     = comb_d[STAGES];
  assign fin_vld = vld_pipe[STAGES];
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= fin_vld;
      if (fin_vld) dout <= DOUT_WIDTH'(fin >> (DIN_WIDTH - DOUT_WIDTH));
    end
  end
endmodule

// File: tb/tb_cic_decim_comb.sv
// Self-checking bench for cic_decim_comb. It runs five configurations side by
// side. A reference model built from the binomial closed form of an N-stage
// comb predicts dout/dout_valid on every cycle. Literal checks pin the
// documented example results.
module tb_cic_decim_comb;
`ifdef CIC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int NU = 5;
  // A: 32/32 N3 R8 M1   B: 32/16 N1 R1 M1   C: 32/32 N1 R8 M1
  // D: 32/32 N3 R4 M1 (fed by a modelled integrator)   E: 24/12 N2 R3 M2
  localparam int PW[NU] = '{32, 32, 32, 32, 24};
  localparam int PO[NU] = '{32, 16, 32, 32, 12};
  localparam int PN[NU] = '{3, 1, 1, 3, 2};
  localparam int PR[NU] = '{8, 1, 8, 4, 3};
  localparam int PM[NU] = '{1, 1, 1, 1, 2};

  logic        clk_in = 1'b0;
  logic        rst;
  logic [31:0] din_w [NU];
  logic [31:0] dout_w [NU];
  logic        vld_w [NU];
  logic [31:0] dout_a, dout_c, dout_d;
  logic [15:0] dout_b;
  logic [11:0] dout_e;
  logic        va, vb, vc, vd, ve;

  always #5 clk_in = ~clk_in;

  cic_decim_comb #(.DIN_WIDTH(32), .DOUT_WIDTH(32), .STAGES(3), .DECIMATION(8), .DIFF_DELAY(1)) u_a (
    .clk_in(clk_in), .rst(rst), .din(din_w[0]), .dout(dout_a), .dout_valid(va));
  cic_decim_comb #(.DIN_WIDTH(32), .DOUT_WIDTH(16), .STAGES(1), .DECIMATION(1), .DIFF_DELAY(1)) u_b (
    .clk_in(clk_in), .rst(rst), .din(din_w[1]), .dout(dout_b), .dout_valid(vb));
  cic_decim_comb #(.DIN_WIDTH(32), .DOUT_WIDTH(32), .STAGES(1), .DECIMATION(8), .DIFF_DELAY(1)) u_c (
    .clk_in(clk_in), .rst(rst), .din(din_w[2]), .dout(dout_c), .dout_valid(vc));
  cic_decim_comb #(.DIN_WIDTH(32), .DOUT_WIDTH(32), .STAGES(3), .DECIMATION(4), .DIFF_DELAY(1)) u_d (
    .clk_in(clk_in), .rst(rst), .din(din_w[3]), .dout(dout_d), .dout_valid(vd));
  cic_decim_comb #(.DIN_WIDTH(24), .DOUT_WIDTH(12), .STAGES(2), .DECIMATION(3), .DIFF_DELAY(2)) u_e (
    .clk_in(clk_in), .rst(rst), .din(din_w[4][23:0]), .dout(dout_e), .dout_valid(ve));

  always_comb begin
    dout_w[0] = dout_a;          vld_w[0] = va;
    dout_w[1] = {16'd0, dout_b}; vld_w[1] = vb;
    dout_w[2] = dout_c;          vld_w[2] = vc;
    dout_w[3] = dout_d;          vld_w[3] = vd;
    dout_w[4] = {20'd0, dout_e}; vld_w[4] = ve;
  end

  int checks = 0;
  int errors = 0;

  function automatic longint mask(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Output of an N-stage comb for decimated sample j (1-based); samples
  // before the first one are zero.
  function automatic longint comb_ref(input longint q[$], input int j, input int n,
                                      input int m, input int w);
    longint s = 0;
    for (int i = 0; i <= n; i++) begin
      int idx = j - 1 - i * m;
      if (idx >= 0) s += ((i % 2) ? -1 : 1) * binom(n, i) * q[idx];
    end
    return s & mask(w);
  endfunction

  function automatic longint reduce(input longint v, input int w, input int o);
    longint s;
    if (RND && w > o) begin
      s = (v + (longint'(1) << (w - o - 1))) & mask(w);
      if (((v >> (w - 1)) & 1) == 0 && ((s >> (w - 1)) & 1) == 1)
        return (longint'(1) << (o - 1)) - 1;
      return s >> (w - o);
    end
    return v >> (w - o);
  endfunction

  function automatic int lat(input int i);
    return PN[i] + 1 + ((RND && PW[i] > PO[i]) ? 1 : 0);
  endfunction

  // Reference model: updated at every rising edge from the inputs seen there.
  int          e [NU];
  longint      q [NU][$];
  bit          exp_v [NU];
  logic [31:0] exp_d [NU];
  bit          armed = 1'b0;

  initial begin
    int ec;
    forever begin
      @(posedge clk_in);
      for (int i = 0; i < NU; i++) begin
        if (rst) begin
          e[i] = 0; q[i].delete(); exp_v[i] = 1'b0; exp_d[i] = '0;
        end else begin
          e[i]++;
          if (e[i] % PR[i] == 0) q[i].push_back(longint'(din_w[i]) & mask(PW[i]));
          ec = e[i] - lat(i);
          if (ec >= 1 && ec % PR[i] == 0) begin
            exp_v[i] = 1'b1;
            exp_d[i] = 32'(reduce(comb_ref(q[i], ec / PR[i], PN[i], PM[i], PW[i]), PW[i], PO[i]));
          end else begin
            exp_v[i] = 1'b0;
          end
        end
      end
      if (rst) armed = 1'b1;
    end
  end

  // Compare every output on every cycle once reset has been seen.
  bit          logging = 1'b0;
  logic [31:0] log_q [NU][$];
  int          first_a_edge = -1;

  initial begin
    forever begin
      @(negedge clk_in);
      if (armed) begin
        for (int i = 0; i < NU; i++) begin
          checks++;
          if (vld_w[i] !== exp_v[i] || dout_w[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL out%0d edge %0d: got valid=%0b dout=%h, want valid=%0b dout=%h",
                     i, e[i], vld_w[i], dout_w[i], exp_v[i], exp_d[i]);
          end
          if (logging && vld_w[i] === 1'b1) begin
            log_q[i].push_back(dout_w[i]);
            if (i == 0 && first_a_edge < 0) first_a_edge = e[0];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Stimulus. mode 0: A constant 100, B two steps; mode 1: random A/B.
  int          cyc = 0;
  logic [31:0] i1 = '0, i2 = '0, i3 = '0;

  task automatic tick(input int mode);
    @(negedge clk_in);
    cyc++;
    din_w[2] = 32'hFFFF_0000 + 32'(cyc) * 32'd1000;
    i1 = i1 + 32'd1; i2 = i2 + i1; i3 = i3 + i2;
    din_w[3] = i3;
    din_w[4] = $urandom;
    if (mode == 0) begin
      din_w[0] = 32'd100;
      din_w[1] = (cyc < 20) ? 32'd0 : (cyc < 40) ? 32'h0001_8000 : 32'h0001_8000 + 32'h7FFF_FFFF;
    end else begin
      din_w[0] = $urandom;
      din_w[1] = $urandom;
    end
  endtask

  initial begin
    logic [31:0] nz [$];
    int bad, cnt;
    rst = 1'b1;
    din_w[0] = 32'd100; din_w[1] = '0; din_w[2] = 32'hFFFF_0000; din_w[3] = '0; din_w[4] = '0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    logging = 1'b1;
    repeat (120) tick(0);
    logging = 1'b0;

    // Constant 100 through three combs: 100, -200, 100, 0.
    chk("a_log_len", log_q[0].size() >= 4, 1);
    if (log_q[0].size() >= 4) begin
      chk("a_out0", log_q[0][0], 32'd100);
      chk("a_out1", log_q[0][1], 32'hFFFF_FF38);
      chk("a_out2", log_q[0][2], 32'd100);
      chk("a_out3", log_q[0][3], 32'd0);
    end
    chk("a_first_valid_edge", first_a_edge, 12);

    // Width reduction: 0x0001_8000 -> 1 (2 when rounded); 0x7FFF_FFFF -> 0x7FFF.
    foreach (log_q[1][k]) if (log_q[1][k] != 0) nz.push_back(log_q[1][k]);
    chk("b_nonzero_count", nz.size(), 2);
    if (nz.size() >= 2) begin
      chk("b_half", nz[0], RND ? 2 : 1);
      chk("b_max", nz[1], 32'h7FFF);
    end

    // Ramp through the 2^32 wrap: every output after the first is 8000.
    bad = 0;
    for (int k = 1; k < log_q[2].size(); k++) if (log_q[2][k] != 32'd8000) bad++;
    chk("c_log_len", log_q[2].size() >= 12, 1);
    chk("c_ramp_bad", bad, 0);

    // Integrator chain + combs on a unit step settles to R^N = 64.
    chk("d_log_len", log_q[3].size() >= 10, 1);
    if (log_q[3].size() >= 10) begin
      chk("d_settle_a", log_q[3][log_q[3].size()-5], 64);
      chk("d_settle_b", log_q[3][log_q[3].size()-1], 64);
    end

    repeat (300) tick(1);

    // Reset while A's first comb stage holds a sample.
    cnt = 0;
    do begin tick(1); cnt++; end while (e[0] % 8 != 0 && cnt < 20);
    chk("a_capture_found", e[0] % 8, 0);
    tick(1);
    rst = 1'b1;
    @(negedge clk_in);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_valid_a", va, 0);
    rst = 1'b0;
    cnt = 0;
    do begin tick(1); cnt++; end while (va !== 1'b1 && cnt < 40);
    chk("a_valid_after_reset", cnt, 12);

    repeat (50) tick(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
